// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : exe_stage_mc
//  Purpose  : Execute stage of the 5-stage pipeline. It performs operand
//             forwarding, single-cycle ALU operations and branch resolution,
//             and holds the EXE/MEM register. Iterative MUL/DIVU/REMU stall
//             the upstream stages through busy. The MEM-stage freeze holds
//             the whole stage.
//  Revision : 1.0 - initial release
// ============================================================================
module exe_stage_mc #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int SH_W   = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic [1:0]        fwd_sel1,
   input  logic [1:0]        fwd_sel2,
   input  logic [1:0]        fwd_sel_src,
   input  logic [3:0]        exe_cmd,
   input  logic [WIDTH-1:0]  val1,
   input  logic [WIDTH-1:0]  val2,
   input  logic [WIDTH-1:0]  reg2,
   input  logic [WIDTH-1:0]  pc,
   input  logic [1:0]        br_type,
   input  logic [WIDTH-1:0]  fwd_alu,
   input  logic [WIDTH-1:0]  fwd_wb,
   input  logic              wb_en_in,
   input  logic [1:0]        mem_sig_in,
   input  logic [ADDR_W-1:0] dest_in,
   output logic [WIDTH-1:0]  br_addr,
   output logic              br_taken,
   output logic              busy,
   output logic              wb_en_out,
   output logic [1:0]        mem_sig_out,
   output logic [ADDR_W-1:0] dest_out,
   output logic [WIDTH-1:0]  pc_out,
   output logic [WIDTH-1:0]  alu_res_out,
   output logic [WIDTH-1:0]  reg2_out
);

   localparam int              CNT_W      = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   localparam logic [3:0] c_ADD  = 4'b0000;
   localparam logic [3:0] c_SUB  = 4'b0010;
   localparam logic [3:0] c_AND  = 4'b0100;
   localparam logic [3:0] c_OR   = 4'b0101;
   localparam logic [3:0] c_NOR  = 4'b0110;
   localparam logic [3:0] c_XOR  = 4'b0111;
   localparam logic [3:0] c_SLL  = 4'b1000;
   localparam logic [3:0] c_SRA  = 4'b1001;
   localparam logic [3:0] c_SRL  = 4'b1010;
   localparam logic [3:0] c_SLT  = 4'b1011;
   localparam logic [3:0] c_MUL  = 4'b1100;
   localparam logic [3:0] c_DIVU = 4'b1110;
   localparam logic [3:0] c_REMU = 4'b1111;

   localparam logic [1:0] c_BR_BEZ = 2'b01;
   localparam logic [1:0] c_BR_BNE = 2'b10;
   localparam logic [1:0] c_BR_JMP = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WIDTH-1:0]  a_q;      // multiplicand (shifts left) / dividend->quotient
   logic [WIDTH-1:0]  b_q;      // multiplier (shifts right) / divisor
   logic [WIDTH-1:0]  acc_q;    // product accumulator / partial remainder
   logic [3:0]        cmd_q;

   logic [WIDTH-1:0]  op1, op2, src2;
   logic [WIDTH-1:0]  alu_d;
   logic [WIDTH-1:0]  mc_res;
   logic [WIDTH:0]    rem_shift;
   logic [WIDTH:0]    rem_sub;
   logic              q_bit;
   logic              is_multi;
   logic              start;
   logic              load_bubble;
   logic [SH_W-1:0]   shamt;

   // Forwarding muxes; select 11 falls back to the ID value
   always_comb begin
      op1  = val1;
      op2  = val2;
      src2 = reg2;
      case (fwd_sel1)
         2'b01:   op1 = fwd_alu;
         2'b10:   op1 = fwd_wb;
         default: op1 = val1;
      endcase
      case (fwd_sel2)
         2'b01:   op2 = fwd_alu;
         2'b10:   op2 = fwd_wb;
         default: op2 = val2;
      endcase
      case (fwd_sel_src)
         2'b01:   src2 = fwd_alu;
         2'b10:   src2 = fwd_wb;
         default: src2 = reg2;
      endcase
   end

   assign shamt    = op2[SH_W-1:0];
   assign is_multi = (exe_cmd == c_MUL) || (exe_cmd == c_DIVU) || (exe_cmd == c_REMU);
   assign start    = (state_q == S_IDLE) && is_multi && wb_en_in && !freeze;
   assign busy     = start || (state_q == S_RUN);
   // Bubbles go into EXE/MEM from the start cycle until the result is ready
   assign load_bubble = busy;

   // Single-cycle ALU; unlisted and multi-cycle codes produce zero here
   always_comb begin
      alu_d = '0;
      case (exe_cmd)
         c_ADD:   alu_d = op1 + op2;
         c_SUB:   alu_d = op1 - op2;
         c_AND:   alu_d = op1 & op2;
         c_OR:    alu_d = op1 | op2;
         c_NOR:   alu_d = ~(op1 | op2);
         c_XOR:   alu_d = op1 ^ op2;
         c_SLL:   alu_d = op1 << shamt;
         c_SRA:   alu_d = $unsigned($signed(op1) >>> shamt);
         c_SRL:   alu_d = op1 >> shamt;
         c_SLT:   alu_d = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         default: alu_d = '0;
      endcase
   end

   // Branch target and condition; suppressed while a multi-cycle op owns the stage
   always_comb begin
      br_addr  = pc + {op2[WIDTH-1:2], 2'b00};
      br_taken = 1'b0;
      if (state_q == S_IDLE) begin
         case (br_type)
            c_BR_BEZ: br_taken = (op1 == '0);
            c_BR_BNE: br_taken = (op1 != src2);
            c_BR_JMP: br_taken = 1'b1;
            default:  br_taken = 1'b0;
         endcase
      end
   end

   // Restoring-divide step: shift in the next dividend bit and try to subtract.
   // A zero divisor always subtracts, giving an all-ones quotient and the
   // dividend as remainder without any special casing.
   assign rem_shift = {acc_q, a_q[WIDTH-1]};
   assign rem_sub   = rem_shift - {1'b0, b_q};
   assign q_bit     = (rem_shift >= {1'b0, b_q});
   assign mc_res    = (cmd_q == c_DIVU) ? a_q : acc_q;

   // Multi-cycle control FSM and iterative datapath, one bit per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cmd_q   <= '0;
      end else if (!freeze) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  a_q     <= op1;
                  b_q     <= op2;
                  acc_q   <= '0;
                  cmd_q   <= exe_cmd;
               end
            end
            S_RUN: begin
               if (cmd_q == c_MUL) begin
                  if (b_q[0]) begin
                     acc_q <= acc_q + a_q;
                  end
                  a_q <= a_q << 1;
                  b_q <= b_q >> 1;
               end else begin
                  acc_q <= q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                  a_q   <= {a_q[WIDTH-2:0], q_bit};
               end
               cnt_q <= cnt_q + c_CNT_ONE;
               if (cnt_q == c_CNT_LAST) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // EXE/MEM pipeline register: bubble while busy, multi-cycle result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_out   <= 1'b0;
         mem_sig_out <= '0;
         dest_out    <= '0;
         pc_out      <= '0;
         alu_res_out <= '0;
         reg2_out    <= '0;
      end else if (!freeze) begin
         if (load_bubble) begin
            wb_en_out   <= 1'b0;
            mem_sig_out <= '0;
            dest_out    <= '0;
            pc_out      <= '0;
            alu_res_out <= '0;
            reg2_out    <= '0;
         end else begin
            wb_en_out   <= wb_en_in;
            mem_sig_out <= mem_sig_in;
            dest_out    <= dest_in;
            pc_out      <= pc;
            reg2_out    <= src2;
            alu_res_out <= (state_q == S_DONE) ? mc_res : alu_d;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_stage_mc
//  Purpose  : Self-checking bench for exe_stage_mc (WIDTH=32) with directed
//             scenarios and randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic [1:0]  fwd_sel1, fwd_sel2, fwd_sel_src;
   logic [3:0]  exe_cmd;
   logic [31:0] val1, val2, reg2, pc, fwd_alu, fwd_wb;
   logic [1:0]  br_type;
   logic        wb_en_in;
   logic [1:0]  mem_sig_in;
   logic [4:0]  dest_in;
   logic [31:0] br_addr;
   logic        br_taken;
   logic        busy;
   logic        wb_en_out;
   logic [1:0]  mem_sig_out;
   logic [4:0]  dest_out;
   logic [31:0] pc_out, alu_res_out, reg2_out;

   int n_checks = 0;
   int n_fail   = 0;

   exe_stage_mc #(.WIDTH(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .fwd_sel_src(fwd_sel_src),
      .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .reg2(reg2), .pc(pc),
      .br_type(br_type), .fwd_alu(fwd_alu), .fwd_wb(fwd_wb),
      .wb_en_in(wb_en_in), .mem_sig_in(mem_sig_in), .dest_in(dest_in),
      .br_addr(br_addr), .br_taken(br_taken), .busy(busy),
      .wb_en_out(wb_en_out), .mem_sig_out(mem_sig_out), .dest_out(dest_out),
      .pc_out(pc_out), .alu_res_out(alu_res_out), .reg2_out(reg2_out)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] v,
                                        input logic [31:0] fa, input logic [31:0] fw);
      if (s == 2'd1) return fa;
      if (s == 2'd2) return fw;
      return v;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      logic [31:0] all1;
      int sa, sb;
      sh   = b % 32;
      all1 = 32'hFFFF_FFFF;
      sa   = a;
      sb   = b;
      case (c)
         4'd0:  return a + b;
         4'd2:  return a - b;
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return ~(a | b);
         4'd7:  return a ^ b;
         4'd8:  return a << sh;
         4'd9:  return (a >> sh) | (a[31] ? ~(all1 >> sh) : 32'd0);
         4'd10: return a >> sh;
         4'd11: return (sa < sb) ? 32'd1 : 32'd0;
         4'd12: return a * b;
         4'd14: return (b == 0) ? all1 : a / b;
         4'd15: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_br(input logic [1:0] t, input logic [31:0] a,
                                   input logic [31:0] s);
      case (t)
         2'd1: return a == 0;
         2'd2: return a != s;
         2'd3: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- helpers ----------------
   task automatic idle_inputs();
      freeze = 0; fwd_sel1 = 0; fwd_sel2 = 0; fwd_sel_src = 0;
      exe_cmd = 0; val1 = 0; val2 = 0; reg2 = 0; pc = 0; br_type = 0;
      fwd_alu = 0; fwd_wb = 0; wb_en_in = 0; mem_sig_in = 0; dest_in = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a multi-cycle op with operands routed through random forwarding
   // paths, optionally freezing for fz_len cycles starting at busy cycle fz_at.
   task automatic run_multi(input logic [3:0] cmd, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] dest,
                            input int fz_at, input int fz_len, input string tag);
      logic [31:0] expv, snap_res;
      int  nbusy;
      bit  done, frz;
      logic [1:0] s1, s2;
      expv = ref_alu(cmd, a, b);
      idle_inputs();
      s1 = 2'($urandom_range(0, 2)); if (s1 == 2'd2) s1 = 2'd3;
      s2 = 2'($urandom_range(0, 2)); if (s2 == 2'd1) s2 = 2'd2;
      fwd_sel1 = s1; fwd_sel2 = s2;
      val1 = (s1 == 2'd1) ? $urandom : a;
      fwd_alu = (s1 == 2'd1) ? a : $urandom;
      val2 = (s2 == 2'd2) ? $urandom : b;
      fwd_wb = (s2 == 2'd2) ? b : $urandom;
      exe_cmd = cmd; wb_en_in = 1; dest_in = dest; pc = $urandom;
      nbusy = 0; done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         frz = (fz_len > 0) && (i >= fz_at) && (i < fz_at + fz_len);
         freeze = frz;
         #1;
         snap_res = alu_res_out;
         if (busy) nbusy++; else done = 1;
         @(posedge clk);
         #1;
         if (!done) begin
            n_checks++;
            if (wb_en_out !== 1'b0) begin
               n_fail++;
               $display("FAIL %s_bubble: cycle %0d wb_en_out=%b required 0", tag, i, wb_en_out);
            end
            if (frz) begin
               n_checks++;
               if (alu_res_out !== snap_res) begin
                  n_fail++;
                  $display("FAIL %s_freeze_hold: alu_res_out=%h required %h", tag, alu_res_out, snap_res);
               end
            end
         end
      end
      freeze = 0;
      n_checks++;
      if (!done || nbusy != 33 + fz_len) begin
         n_fail++;
         $display("FAIL %s_busy_len: busy cycles=%0d done=%0d required %0d", tag, nbusy, done, 33 + fz_len);
      end
      n_checks++;
      if (alu_res_out !== expv || wb_en_out !== 1'b1 || dest_out !== dest) begin
         n_fail++;
         $display("FAIL %s_result: res=%h wb=%b dest=%0d required res=%h wb=1 dest=%0d",
                  tag, alu_res_out, wb_en_out, dest_out, expv, dest);
      end
      wb_en_in = 0; exe_cmd = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      val1 = 32'h55; val2 = 32'h22; exe_cmd = 4'd0; wb_en_in = 1; dest_in = 5'd7; pc = 32'h40;
      tick();
      // reset must win over freeze and also block a multi-cycle start
      rst = 1; freeze = 1; exe_cmd = 4'd12;
      tick();
      tick();
      #1;
      n_checks++;
      if ({wb_en_out, mem_sig_out, dest_out, pc_out, alu_res_out, reg2_out} !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: wb=%b mem=%b dest=%0d pc=%h res=%h r2=%h busy=%b required all 0",
                  wb_en_out, mem_sig_out, dest_out, pc_out, alu_res_out, reg2_out, busy);
      end
      rst = 0;
      idle_inputs();
      tick();
   endtask

   task automatic test_add_fwd();
      idle_inputs();
      val1 = 5; fwd_sel1 = 2'b01; fwd_alu = 7; val2 = 3; exe_cmd = 4'b0000;
      wb_en_in = 1; dest_in = 5'd3;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL add_busy: busy=%b required 0", busy);
      end
      tick();
      n_checks++;
      if (alu_res_out !== 32'd10 || wb_en_out !== 1'b1 || dest_out !== 5'd3) begin
         n_fail++;
         $display("FAIL add_fwd: res=%0d wb=%b dest=%0d required 10 1 3", alu_res_out, wb_en_out, dest_out);
      end
   endtask

   task automatic test_mul();
      run_multi(4'b1100, 32'd1234, 32'd5678, 5'd9, 0, 0, "mul");
      n_checks++;
      if (alu_res_out !== 32'd7006652) begin
         n_fail++; $display("FAIL mul_value: res=%0d required 7006652", alu_res_out);
      end
   endtask

   task automatic test_div();
      run_multi(4'b1110, 32'd100, 32'd7, 5'd1, 0, 0, "divu");
      n_checks++;
      if (alu_res_out !== 32'd14) begin n_fail++; $display("FAIL divu_value: res=%0d required 14", alu_res_out); end
      run_multi(4'b1111, 32'd100, 32'd7, 5'd2, 0, 0, "remu");
      n_checks++;
      if (alu_res_out !== 32'd2) begin n_fail++; $display("FAIL remu_value: res=%0d required 2", alu_res_out); end
      run_multi(4'b1110, 32'd100, 32'd0, 5'd3, 0, 0, "divu0");
      n_checks++;
      if (alu_res_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_value: res=%h required ffffffff", alu_res_out); end
      run_multi(4'b1111, 32'd100, 32'd0, 5'd4, 0, 0, "remu0");
      n_checks++;
      if (alu_res_out !== 32'd100) begin n_fail++; $display("FAIL remu0_value: res=%0d required 100", alu_res_out); end
   endtask

   task automatic test_freeze();
      run_multi(4'b1100, 32'd1234, 32'd5678, 5'd9, 10, 3, "mul_frz");
   endtask

   task automatic test_reset_mid();
      bit ok;
      idle_inputs();
      val1 = 32'd1234; val2 = 32'd5678; exe_cmd = 4'b1100; wb_en_in = 1; dest_in = 5'd9;
      ok = 1;
      for (int i = 0; i < 11; i++) begin
         #1;
         if (!busy) ok = 0;
         tick();
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_busy_before: busy=%b required 1", busy); end
      rst = 1;
      tick();
      rst = 0; exe_cmd = 4'b0000; wb_en_in = 0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || {wb_en_out, mem_sig_out, dest_out, pc_out, alu_res_out, reg2_out} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_clear: busy=%b wb=%b res=%h dest=%0d required all 0", busy, wb_en_out, alu_res_out, dest_out);
      end
      val1 = 2; val2 = 2; wb_en_in = 1; dest_in = 5'd6;
      tick();
      n_checks++;
      if (alu_res_out !== 32'd4 || wb_en_out !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_add: res=%0d wb=%b required 4 1", alu_res_out, wb_en_out);
      end
   endtask

   task automatic test_branch_shift();
      idle_inputs();
      br_type = 2'b10; val1 = 4; fwd_sel_src = 2'b10; fwd_wb = 4; reg2 = 9;
      pc = 32'h100; val2 = 32'h13; wb_en_in = 1;
      #1;
      n_checks++;
      if (br_taken !== 1'b0 || br_addr !== 32'h110) begin
         n_fail++; $display("FAIL bne_fwd: taken=%b addr=%h required 0 110", br_taken, br_addr);
      end
      fwd_sel_src = 2'b00;
      #1;
      n_checks++;
      if (br_taken !== 1'b1) begin n_fail++; $display("FAIL bne_taken: taken=%b required 1", br_taken); end
      br_type = 0; val1 = 32'h8000_0000; val2 = 4; exe_cmd = 4'b1001;
      tick();
      n_checks++;
      if (alu_res_out !== 32'hF800_0000) begin n_fail++; $display("FAIL sra: res=%h required f8000000", alu_res_out); end
      val1 = 32'hFFFF_FFFF; val2 = 1; exe_cmd = 4'b1011;
      tick();
      n_checks++;
      if (alu_res_out !== 32'd1) begin n_fail++; $display("FAIL slt: res=%h required 1", alu_res_out); end
   endtask

   task automatic test_random_single();
      logic [31:0] o1, o2, s2, expv;
      logic [3:0]  c;
      logic        w;
      for (int i = 0; i < 60; i++) begin
         idle_inputs();
         fwd_sel1 = 2'($urandom); fwd_sel2 = 2'($urandom); fwd_sel_src = 2'($urandom);
         val1 = $urandom; val2 = $urandom; reg2 = $urandom; pc = $urandom;
         fwd_alu = $urandom; fwd_wb = $urandom; br_type = 2'($urandom);
         if ($urandom_range(0, 3) == 0) val1 = 0;
         c = 4'($urandom); w = 1'($urandom);
         if (c == 4'd12 || c == 4'd14 || c == 4'd15) w = 0;
         exe_cmd = c; wb_en_in = w; mem_sig_in = 2'($urandom); dest_in = 5'($urandom);
         o1 = pick(fwd_sel1, val1, fwd_alu, fwd_wb);
         o2 = pick(fwd_sel2, val2, fwd_alu, fwd_wb);
         s2 = pick(fwd_sel_src, reg2, fwd_alu, fwd_wb);
         expv = (c == 4'd12 || c == 4'd14 || c == 4'd15) ? 32'd0 : ref_alu(c, o1, o2);
         #1;
         n_checks++;
         if (busy !== 1'b0 || br_taken !== ref_br(br_type, o1, s2) || br_addr !== pc + (o2 & ~32'd3)) begin
            n_fail++;
            $display("FAIL rnd_branch: busy=%b taken=%b addr=%h required 0 %b %h",
                     busy, br_taken, br_addr, ref_br(br_type, o1, s2), pc + (o2 & ~32'd3));
         end
         tick();
         n_checks++;
         if (alu_res_out !== expv || wb_en_out !== w || mem_sig_out !== mem_sig_in ||
             dest_out !== dest_in || pc_out !== pc || reg2_out !== s2) begin
            n_fail++;
            $display("FAIL rnd_single cmd=%h: res=%h wb=%b mem=%b dest=%0d pc=%h r2=%h required %h %b %b %0d %h %h",
                     c, alu_res_out, wb_en_out, mem_sig_out, dest_out, pc_out, reg2_out,
                     expv, w, mem_sig_in, dest_in, pc, s2);
         end
      end
   endtask

   task automatic test_random_multi();
      logic [3:0]  c;
      logic [31:0] a, b;
      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 2))
            0:       c = 4'd12;
            1:       c = 4'd14;
            default: c = 4'd15;
         endcase
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         run_multi(c, a, b, 5'($urandom), $urandom_range(1, 30), $urandom_range(0, 2), "rnd_multi");
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
      test_reset();
      test_add_fwd();
      test_mul();
      test_div();
      test_freeze();
      test_reset_mid();
      test_branch_shift();
      test_random_single();
      test_random_multi();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
